// File: rtl/pipelined_memory.sv
// rtl/pipelined_memory.sv - single-port RAM with valid/ready requests, READ_LATENCY pipeline and optional bounds check (MEMORY_BOUNDS_CHECK_EN)
module pipelined_memory #(
    parameter MEMORY_FILE = "",
    parameter int MEMORY_SIZE = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = MEMORY_SIZE / NB;
    localparam int AW    = $clog2(DEPTH);
    localparam int L     = READ_LATENCY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          stall;
    logic          accept;
    logic          err;

    assign idx       = req_addr[LSB +: AW];
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;

`ifdef MEMORY_BOUNDS_CHECK_EN
    assign err = (req_addr >= 32'(MEMORY_SIZE)) || (req_addr[LSB-1:0] != '0);
`else
    // Index wraps modulo depth; address bits outside the index are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:LSB+AW], req_addr[LSB-1:0]};
    assign err = 1'b0;
`endif

    logic [L-1:0]          st_valid;
    logic [L-1:0]          st_error;
    logic [DATA_WIDTH-1:0] st_rdata [L];
    logic [L-1:0]          in_valid;
    logic [L-1:0]          in_error;
    logic [DATA_WIDTH-1:0] in_rdata [L];
    logic [L-1:0]          move;

    always_comb begin
        in_valid    = '0;
        in_error    = '0;
        in_valid[0] = accept;
        in_error[0] = accept && err;
        in_rdata[0] = (accept && !req_write && !err) ? mem[idx] : '0;
        for (int k = 1; k < L; k++) begin
            in_valid[k] = st_valid[k-1];
            in_error[k] = st_error[k-1];
            in_rdata[k] = st_rdata[k-1];
        end
    end

    // A stage may load when downstream has room: the output stage only
    // when not stalled, inner stages also whenever some stage at or after
    // them (short of the output) holds a bubble.
    always_comb begin
        logic free;
        free = !stall;
        move = '0;
        for (int k = L - 1; k >= 0; k--) begin
            if (k != L - 1 && !st_valid[k]) free = 1'b1;
            move[k] = free;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_error <= '0;
            for (int k = 0; k < L; k++) st_rdata[k] <= '0;
        end else begin
            for (int k = 0; k < L; k++) begin
                if (move[k]) begin
                    st_valid[k] <= in_valid[k];
                    st_error[k] <= in_error[k];
                    st_rdata[k] <= in_rdata[k];
                end
            end
        end
    end

    // Array is never reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_write && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = st_valid[L-1];
    assign rsp_error = st_error[L-1];
    assign rsp_rdata = st_rdata[L-1];
endmodule

// File: tb/tb_pipelined_memory.sv
// tb/tb_pipelined_memory.sv - self-checking bench for pipelined_memory (honours MEMORY_BOUNDS_CHECK_EN)
module tb_pipelined_memory;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    pipelined_memory #(
        .MEMORY_FILE(""),
        .MEMORY_SIZE(4096),
        .DATA_WIDTH(32),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        bit          lit_en;
        logic [32:0] lit;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [int];
    int          vecs = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          timing_on = 1'b1;
    bit          lit_en = 1'b0;
    logic [32:0] lit_val = '0;
    bit          after_rst = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: word-addressed array plus an in-order response queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            after_rst  = 1'b1;
        end else begin
            if (after_rst) begin
                chk("post_reset_rsp_valid", rsp_valid, 0);
                chk("post_reset_req_ready", req_ready, 1);
                chk("post_reset_rsp_rdata", rsp_rdata, 0);
                chk("post_reset_rsp_error", rsp_error, 0);
                after_rst = 1'b0;
            end
            if (prev_stall) begin
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_rdata", rsp_rdata, prev_data);
                chk("hold_rsp_error", rsp_error, prev_err);
            end
            chk("req_ready", req_ready, !(rsp_valid && !rsp_ready));
            if (timing_on && q.size() > 0 && q[0].cyc + LAT == cyc)
                chk("rsp_on_time", rsp_valid, 1);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("stale_rsp_valid", rsp_valid, 0);
                end else if (rsp_ready) begin
                    rsp_t e;
                    e = q.pop_front();
                    pops++;
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_error", rsp_error, e.err);
                    if (e.lit_en) chk("rsp_literal", {rsp_error, rsp_rdata}, e.lit);
                    if (timing_on) chk("rsp_latency", cyc - e.cyc, LAT);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_rdata;
            prev_err   = rsp_error;
            if (req_valid && req_ready) begin
                rsp_t e;
                int   wi;
                logic [31:0] w;
                e.cyc = cyc;
                e.lit_en = lit_en;
                e.lit = lit_val;
`ifdef MEMORY_BOUNDS_CHECK_EN
                e.err = (req_addr >= 32'd4096) || (req_addr % 4 != 0);
`else
                e.err = 1'b0;
`endif
                wi = int'((req_addr / 4) % 1024);
                w  = mm.exists(wi) ? mm[wi] : 32'h0;
                e.data = 32'h0;
                if (req_write) begin
                    if (!e.err) begin
                        for (int i = 0; i < 4; i++)
                            if (req_wstrb[i]) w[8*i +: 8] = req_wdata[8*i +: 8];
                        mm[wi] = w;
                    end
                end else if (!e.err) begin
                    e.data = w;
                end
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit le, input logic [32:0] l);
        int n;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        lit_en = le; lit_val = l; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && rst_n) && n < 100);
        if (n >= 100) chk("req_accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(1'b1, a, d, s, 1'b1, 33'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [32:0] l);
        issue(1'b0, a, 32'h0, 4'h0, 1'b1, l);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // write then read-after-write
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10, {1'b0, 32'hDEADBEEF});
        // byte strobes and empty strobe
        wr(32'h20, 32'h11223344, 4'hF);
        wr(32'h20, 32'hAABBCCDD, 4'b0101);
        rd(32'h20, {1'b0, 32'h11BB33DD});
        wr(32'h20, 32'hFFFFFFFF, 4'h0);
        rd(32'h20, {1'b0, 32'h11BB33DD});
        wr(32'h0, 32'h01010101, 4'hF);
        wr(32'h4, 32'h02020202, 4'hF);
        wr(32'h8, 32'h03030303, 4'hF);
        drain();

        // backpressure from the first response onward
        timing_on = 1'b0;
        rsp_ready = 1'b0;
        p0 = pops;
        rd(32'h0, {1'b0, 32'h01010101});
        rd(32'h4, {1'b0, 32'h02020202});
        fork
            rd(32'h8, {1'b0, 32'h03030303});
            begin
                repeat (4) @(negedge clk);
                chk("stall_req_ready", req_ready, 0);
                chk("stall_rsp_valid", rsp_valid, 1);
                chk("stall_rsp_rdata", rsp_rdata, 32'h01010101);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();
        chk("stall_pop_count", pops - p0, 3);
        timing_on = 1'b1;

        // out-of-range and misaligned accesses
`ifdef MEMORY_BOUNDS_CHECK_EN
        rd(32'h1000, {1'b1, 32'h0});
        issue(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 1'b1, {1'b1, 32'h0});
        rd(32'h0, {1'b0, 32'h01010101});
`else
        rd(32'h1000, {1'b0, 32'h01010101});
`endif
        drain();

        // reset with reads in flight and a write coinciding with reset
        rd(32'h0, {1'b0, 32'h01010101});
        rd(32'h4, {1'b0, 32'h02020202});
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_wdata = 32'hBAD0BAD0; req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rd(32'h0, {1'b0, 32'h01010101});
        rd(32'h4, {1'b0, 32'h02020202});
        drain();

        // throughput: 16 back-to-back writes then 16 back-to-back reads
        for (int i = 0; i < 16; i++)
            wr(32'h100 + 32'(4 * i), 32'h5A000000 + 32'(i * 32'h00010203), 4'hF);
        for (int i = 0; i < 16; i++)
            rd(32'h100 + 32'(4 * i), {1'b0, 32'h5A000000 + 32'(i * 32'h00010203)});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0 cycles left", cyc);
        $fatal(1, "timeout");
    end
endmodule
